stack_program_sequencer: RTL and testbench
==========================================

Name: stack_program_sequencer

Overview:
Parametrised next-generation program sequencer for the nibble-processor family. It generates the program-memory address each cycle and adds capabilities the current sequencer lacks:
- hardware subroutine stack (call/return)
- hardware loop counter (load / decrement-and-jump-if-nonzero)
- stall/hold input
- sticky stack-error flags

It sits between the instruction decoder (control strobes, target address) and program memory (address), with the computational unit's zero flag gating conditional jumps.

Parameters:
ADDR_W, 8, width of program address / pc.
STACK_DEPTH, 4, number of return-address entries (2..16).
LOOP_W, 4, width of loop counter.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous, active-low reset.
stall  input  1  hold current address; all strobes ignored.
jmp  input  1  unconditional jump to jmp_addr.
jmp_nz  input  1  jump to jmp_addr when dont_jmp=0.
dont_jmp  input  1  zero flag from computational unit.
call  input  1  push return address, jump to jmp_addr.
ret  input  1  pop return address, jump to it.
loop_ld  input  1  load loop counter from loop_val.
djnz  input  1  decrement loop counter, jump to jmp_addr if result nonzero.
jmp_addr  input  ADDR_W  target address from decoder.
loop_val  input  LOOP_W  loop-counter load value.
pm_addr  output  ADDR_W  combinational next program-memory address.
pc  output  ADDR_W  registered current address.
from_PS  output  ADDR_W  debug tap, equal to pc.
sp  output  clog2(STACK_DEPTH+1)  stack occupancy.
loop_cnt  output  LOOP_W  current loop counter.
stack_ovf  output  1  sticky: call attempted while full.
stack_unf  output  1  sticky: ret attempted while empty.

Behaviour:
- Reset (reset=0 at a rising edge):
  - pm_addr=0 combinationally while reset is low.
  - pc, sp, loop_cnt, stack_ovf and stack_unf all clear to 0.
  - Stack contents are don't-care.
  - Reset overrides every strobe, including mid-call or mid-loop.
- pc <= pm_addr every edge. pm_addr is a pure function of current state and inputs (zero latency to memory address); pc lags it by one cycle.
- Strobe priority, highest first (one action per cycle):
  1. stall
  2. ret
  3. call
  4. jmp
  5. jmp_nz
  6. djnz
  7. sequential
  Lower-priority strobes asserted in the same cycle are ignored entirely, with no side effects.
- stall: pm_addr=pc; no stack, counter or flag change.
- ret:
  - sp>0: pm_addr=stack[sp-1], sp decrements.
  - sp=0: pm_addr=pc+1, stack_unf<=1.
- call:
  - sp<STACK_DEPTH: stack[sp]<=pc+1, sp increments, pm_addr=jmp_addr.
  - sp=STACK_DEPTH: jump still taken, push dropped, sp unchanged, stack_ovf<=1.
- jmp: pm_addr=jmp_addr.
- jmp_nz: pm_addr = dont_jmp ? pc+1 : jmp_addr.
- djnz:
  - loop_cnt>1: loop_cnt decrements, pm_addr=jmp_addr.
  - loop_cnt=1: loop_cnt<=0, pm_addr=pc+1.
  - loop_cnt=0: no decrement, pm_addr=pc+1 (no wrap to all-ones).
- loop_ld:
  - Not a priority-chain member. It is applied in any non-stall cycle in which djnz does not take effect.
  - loop_ld plus an effective djnz in the same cycle: djnz wins and the load is dropped.
  - Address path is unaffected by loop_ld.
- Sequential: pm_addr=pc+1.
- Arithmetic: pc+1 is computed modulo 2^ADDR_W, so all-ones wraps to 0. A return address pushed from pc=all-ones is 0.
- Flags are sticky until reset; they never block further operation.
- Nested calls are LIFO. Stack entries above sp are not read.

Test Plan:
- Reset then free-run, no strobes: pm_addr sequence 0,1,2,…,255,0 (ADDR_W=8). Reset held low mid-count forces pm_addr=0 and pc=0 on the next edge.
- Nested calls:
  - pc=0x10 call 0x40 → pm_addr=0x40, sp=1.
  - pc=0x41 call 0x80 → sp=2.
  - ret → 0x42; ret → 0x11; sp=0; both flags 0.
- Stack limits (STACK_DEPTH=4):
  - Five calls: fifth jumps but sp stays 4, stack_ovf=1.
  - Four rets return correct addresses; fifth ret → pc+1, stack_unf=1.
- Loop: loop_ld with loop_val=3 at pc=0x20. djnz 0x21 at pc=0x22 → jumps back twice, falls through on the third djnz (pm_addr=0x23), loop_cnt=0. A further djnz falls through and loop_cnt stays 0.
- Conditional jump and priority:
  - jmp_nz 0x30 with dont_jmp=1 → pc+1; with dont_jmp=0 → 0x30.
  - ret+call+jmp together with sp=1 → pop only.
  - stall asserted with jmp → pm_addr=pc, nothing changes.
- loop_ld with djnz in the same cycle, loop_cnt=2: decrement to 1, jump taken, load ignored.

Source files
------------

// File: rtl/stack_program_sequencer.sv
// Program sequencer for the nibble-processor family: next-address generation with
// a hardware call/return stack, a loop counter, stall, and sticky stack-error flags.
module stack_program_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int LOOP_W      = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   stall,
    input  logic                                   jmp,
    input  logic                                   jmp_nz,
    input  logic                                   dont_jmp,
    input  logic                                   call,
    input  logic                                   ret,
    input  logic                                   loop_ld,
    input  logic                                   djnz,
    input  logic [ADDR_W-1:0]                      jmp_addr,
    input  logic [LOOP_W-1:0]                      loop_val,
    output logic [ADDR_W-1:0]                      pm_addr,
    output logic [ADDR_W-1:0]                      pc,
    output logic [ADDR_W-1:0]                      from_PS,
    output logic [$clog2(STACK_DEPTH+1)-1:0]       sp,
    output logic [LOOP_W-1:0]                      loop_cnt,
    output logic                                   stack_ovf,
    output logic                                   stack_unf
);

    localparam int                SP_W     = $clog2(STACK_DEPTH+1);
    localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [LOOP_W-1:0] LOOP_ONE = LOOP_W'(1);

    logic [ADDR_W-1:0] r_pc;
    logic [SP_W-1:0]   r_sp;
    logic [LOOP_W-1:0] r_loop;
    logic              r_ovf;
    logic              r_unf;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_next;
    logic [ADDR_W-1:0] w_top;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic              w_djnz_sel;
    logic              w_loop_dec;

    assign w_pc_inc = r_pc + 1'b1;

    // Top-of-stack read as a mux on sp so no index narrower/wider than the array is needed.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_sp == SP_W'(i + 1)) w_top = r_stack[i];
        end
    end

    always_comb begin
        w_next     = w_pc_inc;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_ovf_set  = 1'b0;
        w_unf_set  = 1'b0;
        w_djnz_sel = 1'b0;
        w_loop_dec = 1'b0;
        if (stall) begin
            w_next = r_pc;
        end else if (ret) begin
            if (r_sp != '0) begin
                w_next = w_top;
                w_pop  = 1'b1;
            end else begin
                w_unf_set = 1'b1;
            end
        end else if (call) begin
            w_next = jmp_addr;
            if (r_sp != SP_FULL) w_push = 1'b1;
            else                 w_ovf_set = 1'b1;
        end else if (jmp) begin
            w_next = jmp_addr;
        end else if (jmp_nz) begin
            w_next = dont_jmp ? w_pc_inc : jmp_addr;
        end else if (djnz) begin
            // A selected djnz always blocks loop_ld, even when the counter is already 0.
            w_djnz_sel = 1'b1;
            w_loop_dec = (r_loop != '0);
            if (r_loop != '0 && r_loop != LOOP_ONE) w_next = jmp_addr;
        end
    end

    assign pm_addr = reset ? w_next : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc   <= '0;
            r_sp   <= '0;
            r_loop <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            r_pc <= w_next;
            if (w_push)     r_sp <= r_sp + 1'b1;
            else if (w_pop) r_sp <= r_sp - 1'b1;
            if (w_loop_dec)
                r_loop <= r_loop - 1'b1;
            else if (loop_ld && !stall && !w_djnz_sel)
                r_loop <= loop_val;
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_unf_set) r_unf <= 1'b1;
        end
    end

    // Stack storage needs no reset; entries at or above sp are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (reset && w_push && r_sp == SP_W'(i)) r_stack[i] <= w_pc_inc;
        end
    end

    assign pc        = r_pc;
    assign from_PS   = r_pc;
    assign sp        = r_sp;
    assign loop_cnt  = r_loop;
    assign stack_ovf = r_ovf;
    assign stack_unf = r_unf;

endmodule

// File: tb/tb_stack_program_sequencer.sv
// Scoreboard bench: the driver pushes expectations from a queue-based reference model,
// a negedge monitor pops and compares them against the sequencer outputs.
module tb_stack_program_sequencer;

    localparam int AW = 8;
    localparam int SD = 4;
    localparam int LW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, stall, jmp, jmp_nz, dont_jmp, call, ret, loop_ld, djnz;
    logic [AW-1:0] jmp_addr;
    logic [LW-1:0] loop_val;
    logic [AW-1:0] pm_addr, pc, from_PS;
    logic [2:0]    sp;
    logic [LW-1:0] loop_cnt;
    logic          stack_ovf, stack_unf;

    stack_program_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .LOOP_W(LW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .jmp(jmp), .jmp_nz(jmp_nz),
        .dont_jmp(dont_jmp), .call(call), .ret(ret), .loop_ld(loop_ld), .djnz(djnz),
        .jmp_addr(jmp_addr), .loop_val(loop_val), .pm_addr(pm_addr), .pc(pc),
        .from_PS(from_PS), .sp(sp), .loop_cnt(loop_cnt), .stack_ovf(stack_ovf),
        .stack_unf(stack_unf)
    );

    typedef struct {
        int pm; int pc; int sp; int lc; int ovf; int unf;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state: program counter, return stack as a queue, loop count, flags.
    int   m_pc = 0;
    int   m_lc = 0;
    int   m_ovf = 0;
    int   m_unf = 0;
    bit   m_known = 1'b0;
    int   m_stk[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("pm_addr",   {24'b0, pm_addr},   e.pm);
            chk("pc",        {24'b0, pc},        e.pc);
            chk("from_PS",   {24'b0, from_PS},   e.pc);
            chk("sp",        {29'b0, sp},        e.sp);
            chk("loop_cnt",  {28'b0, loop_cnt},  e.lc);
            chk("stack_ovf", {31'b0, stack_ovf}, e.ovf);
            chk("stack_unf", {31'b0, stack_unf}, e.unf);
        end
    end

    // One clock of stimulus: drive, predict, enqueue, advance the model, wait for the edge.
    task automatic cyc(input bit rs, input bit st, input bit rt, input bit cl, input bit jp,
                       input bit jnz, input bit dj, input bit dz, input bit ld,
                       input int ja, input int lv);
        exp_t e;
        int   inc;
        int   pm;
        bit   djsel;
        reset = rs; stall = st; ret = rt; call = cl; jmp = jp; jmp_nz = jnz;
        djnz = dj; dont_jmp = dz; loop_ld = ld;
        jmp_addr = ja[AW-1:0];
        loop_val = lv[LW-1:0];
        e.pc = m_pc; e.sp = m_stk.size(); e.lc = m_lc; e.ovf = m_ovf; e.unf = m_unf;
        inc   = (m_pc + 1) % (1 << AW);
        pm    = inc;
        djsel = 1'b0;
        if (!rs) begin
            pm = 0; m_lc = 0; m_ovf = 0; m_unf = 0;
            m_stk.delete();
        end else begin
            if (st) pm = m_pc;
            else if (rt) begin
                if (m_stk.size() > 0) pm = m_stk.pop_back();
                else m_unf = 1;
            end else if (cl) begin
                pm = ja;
                if (m_stk.size() < SD) m_stk.push_back(inc);
                else m_ovf = 1;
            end else if (jp) pm = ja;
            else if (jnz) pm = dz ? inc : ja;
            else if (dj) begin
                djsel = 1'b1;
                if (m_lc > 1) begin
                    m_lc = m_lc - 1;
                    pm = ja;
                end else if (m_lc == 1) m_lc = 0;
            end
            if (!st && !djsel && ld) m_lc = lv;
        end
        e.pm = pm;
        if (m_known) sbq.push_back(e);
        if (!rs) m_known = 1'b1;
        m_pc = pm;
        @(posedge clk);
        #1;
    endtask

    task automatic seq();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rst();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 0; stall = 0; jmp = 0; jmp_nz = 0; dont_jmp = 0; call = 0; ret = 0;
        loop_ld = 0; djnz = 0; jmp_addr = '0; loop_val = '0;

        // Reset, free-run through the wrap, reset mid-count.
        rst(); rst();
        repeat (257) seq();
        repeat (5) seq();
        rst();
        repeat (2) seq();

        // Nested calls and returns.
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 'h10, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 'h40, 0);
        seq();
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 'h80, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        seq();

        // Overflow on the fifth call, underflow on the fifth return.
        rst();
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, $urandom_range(0, 255), 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        seq();

        // Loop of three, then a djnz with the counter already at zero.
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 'h20, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
        seq();
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 'h21, 0);
        seq();
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 'h21, 0);
        seq();
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 'h21, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 'h21, 0);
        seq();

        // Conditional jump, priority of ret over call/jmp, stall over everything.
        cyc(1, 0, 0, 0, 0, 1, 0, 1, 0, 'h30, 0);
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 'h30, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 'h50, 0);
        cyc(1, 0, 1, 1, 1, 0, 0, 0, 0, 'h99, 0);
        cyc(1, 1, 0, 0, 1, 0, 0, 0, 1, 'h77, 9);
        seq();

        // djnz beats a simultaneous loop_ld.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 1, 'h60, 7);
        seq();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 4) == 0, $urandom_range(0, 255), $urandom_range(0, 5));
        end
        seq();

        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
